// File: rtl/pipe_seq_ctrl_if.sv
// Host command, hazard and pipeline-control signals of the sequencing controller.
interface pipe_seq_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             host_run;
    logic             host_step;
    logic             host_halt;
    logic             host_clear;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs2;
    logic             ex_memread;
    logic [4:0]       ex_rd;
    logic             mem_taken;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             pipe_en;
    logic             halted;
    logic [2:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output host_run, host_step, host_halt, host_clear,
        output id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd, mem_taken,
        input  pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, pipe_en,
        input  halted, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  host_run, host_step, host_halt, host_clear,
        input  id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd, mem_taken,
        output pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, pipe_en,
        output halted, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_seq_ctrl.sv
// Five-stage pipeline sequencing and hazard controller: host run/pause/step/halt
// sequencing, load-use stalls, taken-branch flushes and saturating event counters.
module pipe_seq_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic          clk,
    input  logic          reset,
    pipe_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        STEP  = 3'd3,
        DRAIN = 3'd4,
        HALT  = 3'd5
    } state_t;

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    state_t           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             active;
    logic             lu_raw;
    logic             tk;
    logic             lu;

    // Hazard detection, qualified by the active states
    always_comb begin
        active = (state_q == RUN) || (state_q == STEP) || (state_q == DRAIN);
        lu_raw = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                 ((bus.ex_rd == bus.id_rs1) ||
                  (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));
        tk     = active && bus.mem_taken;
        // A taken branch squashes the load-use stall entirely
        lu     = active && lu_raw && !bus.mem_taken;
    end

    // Pipeline enables and flushes from current state and hazards
    always_comb begin
        bus.pc_en       = 1'b0;
        bus.ifid_en     = 1'b0;
        bus.ifid_flush  = 1'b0;
        bus.idex_flush  = 1'b0;
        bus.exmem_flush = 1'b0;
        bus.pipe_en     = 1'b0;
        if (active) begin
            bus.pipe_en = 1'b1;
            if (tk) begin
                bus.pc_en       = 1'b1;
                bus.ifid_en     = 1'b1;
                bus.ifid_flush  = 1'b1;
                bus.idex_flush  = 1'b1;
                bus.exmem_flush = 1'b1;
            end else if (lu) begin
                bus.idex_flush = 1'b1;
            end else begin
                bus.pc_en   = 1'b1;
                bus.ifid_en = 1'b1;
            end
            if (state_q == DRAIN) begin
                bus.pc_en      = 1'b0;
                bus.ifid_flush = 1'b1;
            end
        end
        bus.halted    = (state_q == HALT);
        bus.state     = state_q;
        bus.stall_cnt = stall_q;
        bus.flush_cnt = flush_q;
    end

    // Next-state and drain-counter logic
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            IDLE, PAUSE: begin
                if (bus.host_halt)      state_d = DRAIN;
                else if (bus.host_step) state_d = STEP;
                else if (bus.host_run)  state_d = RUN;
            end
            RUN: begin
                if (bus.host_halt)     state_d = DRAIN;
                else if (!bus.host_run) state_d = PAUSE;
            end
            STEP: begin
                if (bus.host_halt)     state_d = DRAIN;
                else if (bus.host_run) state_d = RUN;
                else                   state_d = PAUSE;
            end
            DRAIN: begin
                if (!lu) begin
                    if (drain_q <= DW'(1)) state_d = HALT;
                    else                   drain_d = drain_q - DW'(1);
                end
            end
            HALT: begin
                if (bus.host_clear) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if ((state_d == DRAIN) && (state_q != DRAIN)) drain_d = DW'(DRAIN_CYCLES);
    end

    // State and drain counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Saturating stall and flush event counters
    always_ff @(posedge clk) begin
        if (reset || bus.host_clear) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (lu && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (tk && (flush_q != '1)) flush_q <= flush_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed-vector bench for pipe_seq_ctrl with hand-computed expectations.
module tb_pipe_seq_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pipe_seq_ctrl_if #(.CNT_W(16)) bus ();

    pipe_seq_ctrl #(.DRAIN_CYCLES(4), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hazards();
        bus.id_rs1      = 5'd0;
        bus.id_rs2      = 5'd0;
        bus.id_uses_rs2 = 1'b0;
        bus.ex_memread  = 1'b0;
        bus.ex_rd       = 5'd0;
        bus.mem_taken   = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        bus.ex_memread = 1'b1;
        bus.ex_rd      = rd;
        bus.id_rs1     = rd;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.host_run   = 1'b0;
        bus.host_step  = 1'b0;
        bus.host_halt  = 1'b0;
        bus.host_clear = 1'b0;
        clear_hazards();
        tick();
        tick();

        // Reset state
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_pc_en", 32'(bus.pc_en), 32'd0);
        check("rst_pipe_en", 32'(bus.pipe_en), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_stall", 32'(bus.stall_cnt), 32'd0);
        check("rst_flush", 32'(bus.flush_cnt), 32'd0);
        reset = 1'b0;

        // Run from IDLE: enables follow one cycle after host_run
        bus.host_run = 1'b1;
        #1;
        check("idle_pc_en", 32'(bus.pc_en), 32'd0);
        tick();
        check("run_state", 32'(bus.state), 32'd1);
        check("run_en", {29'd0, bus.pc_en, bus.ifid_en, bus.pipe_en}, 32'h7);
        check("run_flush", {29'd0, bus.ifid_flush, bus.idex_flush, bus.exmem_flush}, 32'h0);
        tick();
        check("run_en2", {29'd0, bus.pc_en, bus.ifid_en, bus.pipe_en}, 32'h7);

        // Load-use stall on rs1
        set_lu(5'd5);
        #1;
        check("lu_pc_en", 32'(bus.pc_en), 32'd0);
        check("lu_ifid_en", 32'(bus.ifid_en), 32'd0);
        check("lu_idex_flush", 32'(bus.idex_flush), 32'd1);
        check("lu_pipe_en", 32'(bus.pipe_en), 32'd1);
        check("lu_ifid_flush", 32'(bus.ifid_flush), 32'd0);
        tick();
        clear_hazards();
        check("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);

        // Load to x0 never stalls
        set_lu(5'd0);
        #1;
        check("x0_pc_en", 32'(bus.pc_en), 32'd1);
        check("x0_idex_flush", 32'(bus.idex_flush), 32'd0);
        tick();
        clear_hazards();
        check("x0_stall_cnt", 32'(bus.stall_cnt), 32'd1);

        // rs2 match ignored when ID does not read rs2
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd7; bus.id_rs2 = 5'd7; bus.id_rs1 = 5'd1;
        #1;
        check("rs2_unused_pc_en", 32'(bus.pc_en), 32'd1);
        tick();
        clear_hazards();

        // Clear counters, then taken branch with concurrent rs2 load-use
        bus.host_clear = 1'b1;
        tick();
        bus.host_clear = 1'b0;
        check("clr_run_stall", 32'(bus.stall_cnt), 32'd0);
        check("clr_run_state", 32'(bus.state), 32'd1);
        bus.mem_taken = 1'b1; bus.ex_memread = 1'b1; bus.ex_rd = 5'd3;
        bus.id_rs2 = 5'd3; bus.id_uses_rs2 = 1'b1;
        #1;
        check("tk_flushes", {29'd0, bus.ifid_flush, bus.idex_flush, bus.exmem_flush}, 32'h7);
        check("tk_en", {29'd0, bus.pc_en, bus.ifid_en, bus.pipe_en}, 32'h7);
        tick();
        clear_hazards();
        check("tk_flush_cnt", 32'(bus.flush_cnt), 32'd1);
        check("tk_stall_cnt", 32'(bus.stall_cnt), 32'd0);

        // Pause, then single steps
        bus.host_run = 1'b0;
        tick();
        check("pause_state", 32'(bus.state), 32'd2);
        check("pause_en", {29'd0, bus.pc_en, bus.ifid_en, bus.pipe_en}, 32'h0);
        bus.mem_taken = 1'b1;
        #1;
        check("pause_tk_ignored", 32'(bus.exmem_flush), 32'd0);
        tick();
        bus.mem_taken = 1'b0;
        check("pause_flush_cnt", 32'(bus.flush_cnt), 32'd1);
        bus.host_step = 1'b1;
        tick();
        bus.host_step = 1'b0;
        check("step1_state", 32'(bus.state), 32'd3);
        check("step1_pc_en", 32'(bus.pc_en), 32'd1);
        tick();
        check("step1_back", 32'(bus.state), 32'd2);
        check("step1_pc_off", 32'(bus.pc_en), 32'd0);
        tick();
        tick();
        bus.host_step = 1'b1;
        tick();
        bus.host_step = 1'b0;
        set_lu(5'd9);
        #1;
        check("step2_state", 32'(bus.state), 32'd3);
        check("step2_lu_pc_en", 32'(bus.pc_en), 32'd0);
        check("step2_lu_idex", 32'(bus.idex_flush), 32'd1);
        tick();
        clear_hazards();
        check("step2_back", 32'(bus.state), 32'd2);
        check("step2_stall_cnt", 32'(bus.stall_cnt), 32'd1);

        // Halt with drain: one load-use and one taken branch during drain
        bus.host_run = 1'b1;
        tick();
        check("rerun_state", 32'(bus.state), 32'd1);
        bus.host_halt = 1'b1;
        tick();
        bus.host_halt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) set_lu(5'd4);
            if (i == 3) bus.mem_taken = 1'b1;
            #1;
            check("drain_state", 32'(bus.state), 32'd4);
            check("drain_pc_en", 32'(bus.pc_en), 32'd0);
            check("drain_ifid_flush", 32'(bus.ifid_flush), 32'd1);
            if (i == 1) check("drain_lu_idex", 32'(bus.idex_flush), 32'd1);
            if (i == 3) check("drain_tk_exmem", {30'd0, bus.idex_flush, bus.exmem_flush}, 32'h3);
            tick();
            clear_hazards();
        end
        check("halt_state", 32'(bus.state), 32'd5);
        check("halt_halted", 32'(bus.halted), 32'd1);
        check("halt_pc_en", 32'(bus.pc_en), 32'd0);
        check("halt_stall_cnt", 32'(bus.stall_cnt), 32'd2);
        check("halt_flush_cnt", 32'(bus.flush_cnt), 32'd2);
        bus.host_step = 1'b1;
        tick();
        bus.host_step = 1'b0;
        check("halt_hold", 32'(bus.state), 32'd5);
        bus.host_run = 1'b0;
        bus.host_clear = 1'b1;
        tick();
        bus.host_clear = 1'b0;
        check("clr_state", 32'(bus.state), 32'd0);
        check("clr_halted", 32'(bus.halted), 32'd0);
        check("clr_counters", {bus.stall_cnt, bus.flush_cnt}, 32'd0);

        // Stall counter saturation
        bus.host_run = 1'b1;
        tick();
        set_lu(5'd12);
        repeat (65535) tick();
        check("sat_reach", 32'(bus.stall_cnt), 32'hFFFF);
        tick();
        tick();
        clear_hazards();
        check("sat_hold", 32'(bus.stall_cnt), 32'hFFFF);
        check("sat_flush", 32'(bus.flush_cnt), 32'd0);

        // Reset in the middle of a drain
        bus.host_halt = 1'b1;
        tick();
        bus.host_halt = 1'b0;
        tick();
        check("mid_drain", 32'(bus.state), 32'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.host_run = 1'b0;
        check("drain_reset_state", 32'(bus.state), 32'd0);
        check("drain_reset_cnt", 32'(bus.stall_cnt), 32'd0);
        tick();
        check("drain_reset_idle", 32'(bus.state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_seq_ctrl.md
Name: pipe_seq_ctrl

Overview:
- Sequencing and hazard controller for the five-stage pipeline. It produces PC and pipeline-register enables and flushes.
- Host commands are run, pause, single-step and halt-with-drain, arriving from the software register interface.
- It inserts load-use stalls and flushes after a branch or jump taken in MEM.
- It counts stall and flush events for host readback.

Parameters:
DRAIN_CYCLES, 4, advancing cycles needed to empty the pipeline after halt request
CNT_W, 16, width of stall_cnt and flush_cnt

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
host_run  input  1  level; 1 = free-run, 0 = pause
host_step  input  1  one-cycle pulse; advance pipeline one cycle while paused
host_halt  input  1  one-cycle pulse; stop fetch, drain, enter HALT
host_clear  input  1  one-cycle pulse; HALT->IDLE and zero counters
id_rs1  input  5  source reg 1 of instruction in ID
id_rs2  input  5  source reg 2 of instruction in ID
id_uses_rs2  input  1  ID instruction reads rs2 (R-type, store, branch)
ex_memread  input  1  EX instruction is a load (MemtoReg and RegWrite)
ex_rd  input  5  destination reg of EX instruction
mem_taken  input  1  branch/jump resolved taken in MEM this cycle
pc_en  output  1  PC register load enable
ifid_en  output  1  IF/ID register enable
ifid_flush  output  1  IF/ID loads bubble
idex_flush  output  1  ID/EX loads bubble
exmem_flush  output  1  EX/MEM loads bubble
pipe_en  output  1  enable for ID/EX, EX/MEM, MEM/WB registers
halted  output  1  1 in HALT state
state  output  3  IDLE=0 RUN=1 PAUSE=2 STEP=3 DRAIN=4 HALT=5
stall_cnt  output  CNT_W  load-use stall cycles, saturating
flush_cnt  output  CNT_W  taken-branch flush events, saturating

Behaviour:
- State is registered. All enables and flushes are combinational from state plus hazard inputs, so they take effect in the same cycle.
- Reset: state=IDLE, drain counter=0, stall_cnt=0, flush_cnt=0.
  - In IDLE, PAUSE and HALT: every enable and flush output is 0 and halted=0, except in HALT where halted=1.
  - Reset mid-DRAIN or mid-STEP returns to IDLE next cycle and does not complete the drain.
- Hazard terms, evaluated only in the active states RUN, STEP and DRAIN:
  - lu = ex_memread & (ex_rd!=0) & ((ex_rd==id_rs1) | (id_uses_rs2 & (ex_rd==id_rs2))).
  - tk = mem_taken.
- Active-state outputs, priority tk > lu > normal:
  - tk: pc_en=1 (PC takes the target from the datapath); ifid_flush=idex_flush=exmem_flush=1; pipe_en=1; ifid_en=1. flush_cnt += 1. Any lu in the same cycle is suppressed and not counted.
  - lu (no tk): pc_en=0; ifid_en=0; idex_flush=1; pipe_en=1. stall_cnt += 1.
  - normal: pc_en=1, ifid_en=1, pipe_en=1, no flushes.
- DRAIN overrides:
  - pc_en=0 and ifid_flush=1 every cycle, so no new fetch enters.
  - tk still asserts idex_flush and exmem_flush; pc_en stays 0.
  - lu stall applies as above.
- Counters saturate at 2^CNT_W-1. host_clear zeroes both counters in any state.
- Transitions are evaluated per cycle; host_halt has priority over host_step, and host_step over host_run.
  - IDLE: host_halt->DRAIN; host_step->STEP; host_run->RUN.
  - RUN: host_halt->DRAIN; !host_run->PAUSE; else stay.
  - PAUSE: host_halt->DRAIN; host_step->STEP; host_run->RUN.
  - STEP: exactly one active cycle, then host_halt->DRAIN, else host_run->RUN, else PAUSE. A step that lands on lu yields one stall cycle; the host must step again.
  - DRAIN: on entry the counter loads DRAIN_CYCLES. It decrements on each non-lu cycle and holds on lu cycles. When it reaches 1 with no lu, next state is HALT. Host inputs other than reset are ignored.
  - HALT: host_clear->IDLE; all else ignored.
- host_step and host_halt outside their listed states are ignored (e.g. host_step in RUN).

Test Plan:
- Reset, host_run=1, no hazards -> state 0 then 1; pc_en=ifid_en=pipe_en=1 every cycle from the cycle after run; counters stay 0.
- RUN, ex_memread=1, ex_rd=5, id_rs1=5 for one cycle -> that cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- RUN, mem_taken=1 with concurrent lu (ex_rd=3, id_rs2=3, id_uses_rs2=1) -> all three flushes=1, pc_en=1; flush_cnt=1, stall_cnt=0.
- PAUSE, host_step pulse -> exactly one cycle with pc_en=1, then state=2 with all enables 0. Two pulses 3 cycles apart -> two advance cycles.
- RUN, host_halt pulse, one lu during drain -> pc_en=0 throughout, ifid_flush=1; halted=1 after 5 DRAIN cycles (4 plus 1 stall). host_clear -> IDLE, counters 0.
- Preload stall_cnt to 0xFFFF via 65535 stall cycles, apply one more lu -> stall_cnt stays 0xFFFF; reset during DRAIN -> IDLE next cycle.
